ddr2_local_burst_master: RTL and testbench
==========================================

Name: ddr2_local_burst_master

Overview:
- Upstream neighbour of the DDR2 HPC-II controller/PHY wrapper. It converts a simple command/stream interface from camera-side logic into the controller's local_* burst protocol on phy_clk.
- Issues one write burst or one read burst per command and holds every request until local_ready accepts it.
- Tracks outstanding read beats and returns read data unbuffered.

Parameters:
- ADDR_W, 24, local word address width (64-bit words).
- DATA_W, 64, local data width.
- BE_W, 8, byte-enable width (DATA_W/8).
- SIZE_W, 4, local_size width.
- MAX_BURST, 8, largest legal cmd_len.
- MAX_RD_BEATS, 32, cap on read beats issued but not yet returned.

Ports:
- clk  in  1  phy_clk from the controller/PHY wrapper.
- reset_n  in  1  asynchronous active-low reset; connect to reset_phy_clk_n.
- local_init_done  in  1  calibration complete.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  SIZE_W  beats, 1..MAX_BURST.
- cmd_err  out  1  one-cycle pulse when an illegal command is dropped.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat taken.
- wr_data  in  DATA_W  write beat data.
- wr_be  in  BE_W  write beat byte enables.
- rd_valid  out  1  read beat valid; no backpressure.
- rd_data  out  DATA_W  read beat data.
- rd_outstanding  out  6  read beats in flight.
- busy  out  1  state!=IDLE or rd_outstanding!=0.
- local_address  out  ADDR_W  burst address.
- local_size  out  SIZE_W  burst length.
- local_burstbegin  out  1  first-cycle burst marker.
- local_write_req  out  1  write request.
- local_read_req  out  1  read request.
- local_wdata  out  DATA_W  write data.
- local_be  out  BE_W  byte enables.
- local_ready  in  1  controller accepts the current beat or read command.
- local_rdata  in  DATA_W  read data.
- local_rdata_valid  in  1  read data valid.

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, rd_outstanding 0.
- Registered outputs: all local_* outputs and rd_* outputs come from flops.
- FSM states:
  - IDLE:
    - cmd_ready = local_init_done && (cmd_write || rd_outstanding+cmd_len <= MAX_RD_BEATS).
    - On accept with cmd_len==0 or cmd_len>MAX_BURST: pulse cmd_err next cycle, stay in IDLE, generate no local traffic.
    - On accept of a legal write: latch address/size into local_address/local_size, load beats_left=cmd_len, go to WR.
    - On accept of a legal read: go to RD.
  - WR:
    - wr_ready = beats_left!=0 && (!local_write_req || local_ready).
    - On a wr beat, next cycle: local_write_req=1, local_wdata/local_be loaded, beats_left decrements.
    - local_write_req drops after a beat is accepted if no new beat is loaded in the same cycle. Gaps between beats are legal.
    - local_burstbegin=1 for exactly one cycle, coincident with the first cycle local_write_req rises in the burst, regardless of local_ready.
    - Exit to IDLE on the cycle after the last beat is accepted (beats_left==0 && local_write_req && local_ready).
  - RD:
    - local_read_req=1 and local_burstbegin=1 for the first cycle only; address and size are held.
    - On local_ready: local_read_req drops next cycle, rd_outstanding += local_size, return to IDLE.
- Latency: command accept to first local request is 1 cycle (read), or 1 cycle after the first wr beat (write). Minimum command-to-command spacing is 1 idle cycle.
- Read return: rd_valid/rd_data = local_rdata_valid/local_rdata delayed by 1 cycle. rd_outstanding decrements by 1 per local_rdata_valid.
- Simultaneous read accept and rdata_valid: net change is size-1.
- rd_outstanding never exceeds MAX_RD_BEATS. An rdata_valid arriving with rd_outstanding==0 is still forwarded; the counter saturates at 0.
- local_init_done deasserting mid-burst: the current burst completes, then cmd_ready stays low.
- Reset mid-burst: everything returns to reset values asynchronously. Partially issued bursts are abandoned; the controller is reset by the same signal.

Decomposition:
- Package ddr2_local_pkg holds:
  - the state enum (IDLE, WR, RD);
  - default widths ADDR_W/DATA_W/SIZE_W;
  - the MAX_BURST/MAX_RD_BEATS constants;
  - an outstanding-counter width function, clog2(MAX_RD_BEATS+1).
- One natural sub-module: ddr2_rd_credit_counter. It implements the saturating up-by-N/down-by-1 counter with an ok-to-issue compare against MAX_RD_BEATS.

Test Plan:
- Write, len=4, addr=0x000100, wr_valid continuous, local_ready=1 → 4 cycles of local_write_req, burstbegin on beat 0 only, local_size=4, data/be match in order, back to IDLE, busy low.
- Write, len=8, local_ready low on beats 2 and 5 for 3 cycles each → local_wdata held stable through each stall, no beat lost or duplicated, wr_ready low during the stalls.
- Read, len=8 @0x00FF00, local_ready delayed 5 cycles → local_read_req and burstbegin held; burstbegin high 1 cycle only; rd_outstanding=8; 8 rdata_valid beats return on rd_valid 1 cycle later and the count reaches 0.
- Four back-to-back reads of len=8 with no data returned → the 5th read is stalled (cmd_ready=0) at rd_outstanding=32. One rdata_valid arriving in the same cycle as a read accept gives a net count of 32-1+8 = 39? Illegal: the bench must check this never occurs. cmd_ready rises only once the count is ≤24.
- cmd_len=0 and cmd_len=9 → cmd_err pulses 1 cycle each, no local_* activity.
- reset_n asserted mid-write-burst and local_init_done=0 at startup → all outputs 0 immediately; cmd_ready=0 until local_init_done=1.

Source files
------------

// File: rtl/ddr2_local_pkg.sv
// Shared types and constants for the DDR2 local-interface burst master.
package ddr2_local_pkg;

    // Default local-interface widths (64-bit words).
    localparam int unsigned DefAddrW = 24;
    localparam int unsigned DefDataW = 64;
    localparam int unsigned DefSizeW = 4;

    // Largest legal command length and cap on read beats in flight.
    localparam int unsigned MaxBurst   = 8;
    localparam int unsigned MaxRdBeats = 32;

    // Width needed to count 0..max_beats inclusive.
    function automatic int unsigned rd_cnt_width(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

    localparam int unsigned RdCntW = rd_cnt_width(MaxRdBeats);

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd
    } state_e;

endpackage

// File: rtl/ddr2_rd_credit_counter.sv
// Read-beat credit counter: adds a whole burst when a read is issued, removes
// one beat per returned data word, never wraps below zero, and reports whether
// a further request of req_len_i beats still fits under MaxBeats.
module ddr2_rd_credit_counter #(
    parameter int unsigned MaxBeats = 32,
    parameter int unsigned SizeW    = 4,
    parameter int unsigned CntW     = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             add_i,
    input  logic [SizeW-1:0] add_len_i,
    input  logic             dec_i,
    input  logic [SizeW-1:0] req_len_i,
    output logic [CntW-1:0]  cnt_o,
    output logic             ok_o
);

    // One extra bit so sums above MaxBeats are visible before clamping.
    localparam int unsigned SumW = CntW + 1;
    localparam logic [SumW-1:0] MaxS = SumW'(MaxBeats);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SumW-1:0] sum_add, sum_dec, req_sum;

    // Next count: add burst, then retire one beat unless already empty.
    always_comb begin
        sum_add = {1'b0, cnt_q} + (add_i ? SumW'(add_len_i) : '0);
        sum_dec = sum_add;
        if (dec_i && (sum_add != '0)) begin
            sum_dec = sum_add - SumW'(1);
        end
        cnt_d = (sum_dec > MaxS) ? MaxS[CntW-1:0] : sum_dec[CntW-1:0];
    end

    // Issue permission: the requested burst must fit under the cap.
    always_comb begin
        req_sum = {1'b0, cnt_q} + SumW'(req_len_i);
        ok_o    = (req_sum <= MaxS);
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ddr2_local_burst_master.sv
// Converts a command/stream interface into DDR2 HPC-II local_* bursts.
// One write or read burst per command; every request is held until
// local_ready. Read data is forwarded unbuffered one cycle late while a
// credit counter bounds the number of read beats in flight.
module ddr2_local_burst_master
    import ddr2_local_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned BE_W         = DefDataW / 8,
    parameter int unsigned SIZE_W       = DefSizeW,
    parameter int unsigned MAX_BURST    = MaxBurst,
    parameter int unsigned MAX_RD_BEATS = MaxRdBeats
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              local_init_done,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SIZE_W-1:0] cmd_len,
    output logic              cmd_err,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,

    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [RdCntW-1:0] rd_outstanding,
    output logic              busy,

    output logic [ADDR_W-1:0] local_address,
    output logic [SIZE_W-1:0] local_size,
    output logic              local_burstbegin,
    output logic              local_write_req,
    output logic              local_read_req,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid
);

    localparam logic [SIZE_W-1:0] MaxLen = SIZE_W'(MAX_BURST);

    state_e            state_q, state_d;
    logic [SIZE_W-1:0] beats_left_q, beats_left_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              burstbegin_q, burstbegin_d;
    logic              write_req_q, write_req_d;
    logic              read_req_q, read_req_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              cmd_err_q, cmd_err_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              len_bad;
    logic              credit_ok;
    logic              credit_add;
    logic              cmd_ready_c;
    logic              wr_ready_c;
    logic [RdCntW-1:0] rd_cnt;

    assign len_bad = (cmd_len == '0) || (cmd_len > MaxLen);

    ddr2_rd_credit_counter #(
        .MaxBeats (MAX_RD_BEATS),
        .SizeW    (SIZE_W),
        .CntW     (RdCntW)
    ) u_rd_credit (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .add_i     (credit_add),
        .add_len_i (size_q),
        .dec_i     (local_rdata_valid),
        .req_len_i (cmd_len),
        .cnt_o     (rd_cnt),
        .ok_o      (credit_ok)
    );

    // Next-state, request generation and handshake readies.
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        first_d      = first_q;
        addr_d       = addr_q;
        size_d       = size_q;
        burstbegin_d = 1'b0;
        write_req_d  = write_req_q;
        read_req_d   = read_req_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        cmd_err_d    = 1'b0;
        cmd_ready_c  = 1'b0;
        wr_ready_c   = 1'b0;
        credit_add   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Writes need no read credit; reads must fit under the cap.
                cmd_ready_c = local_init_done && (cmd_write || credit_ok);
                if (cmd_valid && cmd_ready_c) begin
                    if (len_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        addr_d = cmd_addr;
                        size_d = cmd_len;
                        if (cmd_write) begin
                            beats_left_d = cmd_len;
                            first_d      = 1'b1;
                            state_d      = StWr;
                        end else begin
                            read_req_d   = 1'b1;
                            burstbegin_d = 1'b1;
                            state_d      = StRd;
                        end
                    end
                end
            end

            StWr: begin
                // A new beat may replace the presented one in its accept cycle.
                wr_ready_c = (beats_left_q != '0) && (!write_req_q || local_ready);
                if (wr_valid && wr_ready_c) begin
                    write_req_d  = 1'b1;
                    wdata_d      = wr_data;
                    be_d         = wr_be;
                    beats_left_d = beats_left_q - SIZE_W'(1);
                    burstbegin_d = first_q;
                    first_d      = 1'b0;
                end else if (write_req_q && local_ready) begin
                    write_req_d = 1'b0;
                    if (beats_left_q == '0) begin
                        state_d = StIdle;
                    end
                end
            end

            StRd: begin
                if (local_ready) begin
                    read_req_d = 1'b0;
                    credit_add = 1'b1;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst bookkeeping and registered local_* outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beats_left_q <= '0;
            first_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            burstbegin_q <= 1'b0;
            write_req_q  <= 1'b0;
            read_req_q   <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            beats_left_q <= beats_left_d;
            first_q      <= first_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            burstbegin_q <= burstbegin_d;
            write_req_q  <= write_req_d;
            read_req_q   <= read_req_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // Read return path: one-cycle pipeline, no backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= local_rdata_valid;
            rd_data_q  <= local_rdata;
        end
    end

    assign cmd_ready        = cmd_ready_c;
    assign wr_ready         = wr_ready_c;
    assign cmd_err          = cmd_err_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign rd_outstanding   = rd_cnt;
    assign busy             = (state_q != StIdle) || (rd_cnt != '0);
    assign local_address    = addr_q;
    assign local_size       = size_q;
    assign local_burstbegin = burstbegin_q;
    assign local_write_req  = write_req_q;
    assign local_read_req   = read_req_q;
    assign local_wdata      = wdata_q;
    assign local_be         = be_q;

endmodule

// File: tb/tb_ddr2_local_burst_master.sv
// Scoreboard bench for ddr2_local_burst_master: write beats and read return
// words are queued when driven and popped when the DUT presents them.
module tb_ddr2_local_burst_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        local_init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        cmd_err;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_be = '0;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [5:0]  rd_outstanding;
    logic        busy;
    logic [23:0] local_address;
    logic [3:0]  local_size;
    logic        local_burstbegin;
    logic        local_write_req;
    logic        local_read_req;
    logic [63:0] local_wdata;
    logic [7:0]  local_be;
    logic        local_ready = 1'b0;
    logic [63:0] local_rdata = '0;
    logic        local_rdata_valid = 1'b0;

    int n_total = 0;
    int n_bad = 0;
    int exp_out = 0;
    int rd_seq = 0;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  be;
    } beat_t;

    beat_t       wq[$];
    logic [63:0] rq[$];
    beat_t       mon_b;
    logic [63:0] mon_r;

    ddr2_local_burst_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .local_init_done   (local_init_done),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .cmd_err           (cmd_err),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .wr_be             (wr_be),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .rd_outstanding    (rd_outstanding),
        .busy              (busy),
        .local_address     (local_address),
        .local_size        (local_size),
        .local_burstbegin  (local_burstbegin),
        .local_write_req   (local_write_req),
        .local_read_req    (local_read_req),
        .local_wdata       (local_wdata),
        .local_be          (local_be),
        .local_ready       (local_ready),
        .local_rdata       (local_rdata),
        .local_rdata_valid (local_rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input logic [23:0] a, input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(a) << 8) | 64'(i);
    endfunction

    function automatic logic [7:0] wbe(input int i);
        logic [7:0] ones;
        ones = 8'hFF;
        return ones >> i;
    endfunction

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pops on accepted write beats and on returned read words.
    always @(negedge clk) begin
        if (reset_n) begin
            if (local_write_req && local_ready) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_b = wq.pop_front();
                    check("wdata", local_wdata, mon_b.d);
                    check("wbe", 64'(local_be), 64'(mon_b.be));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_r = rq.pop_front();
                    check("rd_data", rd_data, mon_r);
                end
            end
            check("rd_cap", 64'(rd_outstanding <= 6'd32), 64'd1);
        end
    end

    task automatic send_cmd(input logic w, input logic [23:0] a, input logic [3:0] l,
                            input int budget, output logic ok);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        ok        = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] addr, input int len, input int st_a,
                            input int st_b);
        logic ok;
        int sent, acc, stall, req_cyc;
        logic seen, done_a, done_b;
        logic [63:0] hold;
        beat_t b;
        sent = 0; acc = 0; stall = 0; req_cyc = 0;
        seen = 1'b0; done_a = 1'b0; done_b = 1'b0; hold = '0;
        local_ready = 1'b1;
        send_cmd(1'b1, addr, 4'(len), 20, ok);
        check("wr_cmd_acc", 64'(ok), 64'd1);
        for (int c = 0; c < 100 && acc < len; c++) begin
            if (stall == 0 && local_write_req &&
                ((acc == st_a && !done_a) || (acc == st_b && !done_b))) begin
                stall = 3;
                hold  = wdat(addr, acc);
                if (acc == st_a) done_a = 1'b1;
                else done_b = 1'b1;
            end
            local_ready = (stall == 0);
            wr_valid    = (sent < len);
            wr_data     = wdat(addr, sent);
            wr_be       = wbe(sent);
            @(negedge clk);
            if (local_write_req && !seen) begin
                check("wr_addr", 64'(local_address), 64'(addr));
                check("wr_size", 64'(local_size), 64'(len));
            end
            check("wr_bb", 64'(local_burstbegin), 64'(local_write_req && !seen));
            if (local_write_req) begin
                seen = 1'b1;
                req_cyc++;
            end
            if (stall != 0) begin
                check("wr_rdy_stall", 64'(wr_ready), 64'd0);
                check("wdata_hold", local_wdata, hold);
                stall--;
            end
            if (wr_valid && wr_ready) begin
                b.d  = wr_data;
                b.be = wr_be;
                wq.push_back(b);
                sent++;
            end
            if (local_write_req && local_ready) acc++;
            tick();
        end
        wr_valid = 1'b0;
        check("wr_beats", 64'(acc), 64'(len));
        check("wr_req_cycles", 64'(req_cyc),
              64'(len + ((st_a < len) ? 3 : 0) + ((st_b < len) ? 3 : 0)));
        @(negedge clk);
        check("wr_idle_busy", 64'(busy), 64'd0);
        check("wr_req_low", 64'(local_write_req), 64'd0);
        check("wr_q_empty", 64'(wq.size()), 64'd0);
        tick();
    endtask

    task automatic do_read(input logic [23:0] addr, input int len, input int dly);
        logic ok;
        local_ready = 1'b0;
        send_cmd(1'b0, addr, 4'(len), 20, ok);
        check("rd_cmd_acc", 64'(ok), 64'd1);
        for (int c = 0; c <= dly; c++) begin
            local_ready = (c == dly);
            @(negedge clk);
            check("rd_req", 64'(local_read_req), 64'd1);
            check("rd_bb", 64'(local_burstbegin), 64'(c == 0));
            check("rd_addr", 64'(local_address), 64'(addr));
            check("rd_size", 64'(local_size), 64'(len));
            tick();
        end
        local_ready = 1'b0;
        exp_out += len;
        @(negedge clk);
        check("rd_req_drop", 64'(local_read_req), 64'd0);
        check("rd_cnt", 64'(rd_outstanding), 64'(exp_out));
        tick();
    endtask

    task automatic return_beats(input int n);
        for (int i = 0; i < n; i++) begin
            local_rdata_valid = 1'b1;
            local_rdata       = 64'hBEEF_0000_0000_0000 | 64'(rd_seq);
            rq.push_back(local_rdata);
            rd_seq++;
            tick();
            if (exp_out > 0) exp_out--;
        end
        local_rdata_valid = 1'b0;
        @(negedge clk);
        check("ret_cnt", 64'(rd_outstanding), 64'(exp_out));
        tick();
        check("rd_q_empty", 64'(rq.size()), 64'd0);
    endtask

    task automatic do_bad(input logic w, input logic [3:0] l);
        logic ok;
        send_cmd(w, 24'h000200, l, 20, ok);
        check("bad_acc", 64'(ok), 64'd1);
        @(negedge clk);
        check("cmd_err_pulse", 64'(cmd_err), 64'd1);
        check("bad_no_wr", 64'(local_write_req), 64'd0);
        check("bad_no_rd", 64'(local_read_req), 64'd0);
        check("bad_no_bb", 64'(local_burstbegin), 64'd0);
        check("bad_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        check("cmd_err_drop", 64'(cmd_err), 64'd0);
        check("bad_no_rd2", 64'(local_read_req || local_write_req), 64'd0);
        tick();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_wreq"}, 64'(local_write_req), 64'd0);
        check({pfx, "_rreq"}, 64'(local_read_req), 64'd0);
        check({pfx, "_bb"}, 64'(local_burstbegin), 64'd0);
        check({pfx, "_addr"}, 64'(local_address), 64'd0);
        check({pfx, "_size"}, 64'(local_size), 64'd0);
        check({pfx, "_wdata"}, local_wdata, 64'd0);
        check({pfx, "_be"}, 64'(local_be), 64'd0);
        check({pfx, "_busy"}, 64'(busy), 64'd0);
        check({pfx, "_wrdy"}, 64'(wr_ready), 64'd0);
        check({pfx, "_crdy"}, 64'(cmd_ready), 64'd0);
        check({pfx, "_rdv"}, 64'(rd_valid), 64'd0);
        check({pfx, "_cnt"}, 64'(rd_outstanding), 64'd0);
        check({pfx, "_err"}, 64'(cmd_err), 64'd0);
    endtask

    initial begin
        int acc_c;
        int acc_cnt;
        logic ok;

        // Reset with calibration pending.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("cr_no_init", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid = 1'b0;
        local_init_done = 1'b1;
        @(negedge clk);
        check("cr_init", 64'(cmd_ready), 64'd1);
        tick();

        // Plain write, then stalled write.
        do_write(24'h000100, 4, 99, 99);
        do_write(24'h000400, 8, 2, 5);

        // Read with delayed acceptance and full return.
        do_read(24'h00FF00, 8, 5);
        return_beats(8);

        // Fill read credit to the cap.
        for (int i = 0; i < 4; i++) begin
            do_read(24'h001000 + 24'(i * 8), 8, 0);
        end
        check("cnt_full", 64'(rd_outstanding), 64'd32);

        // Fifth read waits until the count has dropped to 24.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 24'h000800;
        cmd_len   = 4'd8;
        local_ready = 1'b1;
        acc_c = -1;
        acc_cnt = -1;
        for (int c = 0; c < 12; c++) begin
            local_rdata_valid = 1'b1;
            local_rdata = 64'hBEEF_0000_0000_0000 | 64'(rd_seq);
            rq.push_back(local_rdata);
            rd_seq++;
            @(negedge clk);
            check("cnt_model", 64'(rd_outstanding), 64'(exp_out));
            if (acc_c < 0) check("cr_gate", 64'(cmd_ready), 64'(exp_out <= 24));
            if (acc_c >= 0 && c == acc_c + 1) check("rd5_req", 64'(local_read_req), 64'd1);
            if (cmd_valid && cmd_ready && acc_c < 0) begin
                acc_c = c;
                acc_cnt = exp_out;
            end
            tick();
            if (acc_c >= 0) cmd_valid = 1'b0;
            exp_out = exp_out - 1 + ((acc_c >= 0 && c == acc_c + 1) ? 8 : 0);
        end
        local_rdata_valid = 1'b0;
        cmd_valid = 1'b0;
        local_ready = 1'b0;
        check("rd5_acc_cnt", 64'(acc_cnt), 64'd24);
        check("rd5_acc_cycle", 64'(acc_c), 64'd8);
        @(negedge clk);
        check("cnt_after_rd5", 64'(rd_outstanding), 64'd28);
        tick();
        return_beats(28);
        // Stray beat at zero: forwarded, count stays at zero.
        return_beats(1);
        check("cnt_sat0", 64'(rd_outstanding), 64'd0);

        // Illegal lengths.
        do_bad(1'b1, 4'd0);
        do_bad(1'b0, 4'd9);

        // Asynchronous reset in the middle of a write burst.
        local_ready = 1'b0;
        send_cmd(1'b1, 24'h000300, 4'd8, 20, ok);
        check("mid_acc", 64'(ok), 64'd1);
        wr_valid = 1'b1;
        wr_data  = wdat(24'h000300, 0);
        wr_be    = 8'hFF;
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 64'(local_write_req), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #1;
        reset_n = 1'b0;
        local_init_done = 1'b0;
        #1;
        check_all_zero("mid");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        @(negedge clk);
        check("cr_post_rst", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
